// File: rtl/bus_arb_pkg.sv
// ============================================================================
// Module   : bus_arb_pkg
// Brief    : Shared state encodings and bus field widths for the bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_arb_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bus_arb_if.sv
// ============================================================================
// Module   : bus_arb_if
// Brief    : Two-master ECO32 bus bundle (masters, slave mux, watchdog report).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_arb_if;
    import bus_arb_pkg::*;

    logic              m0_stb;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_dout;
    logic [DATA_W-1:0] m0_din;
    logic              m0_ack;
    logic              m1_stb;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_dout;
    logic [DATA_W-1:0] m1_din;
    logic              m1_ack;
    logic              bus_stb;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_dout;
    logic [DATA_W-1:0] bus_din;
    logic              bus_ack;
    logic              tmo;
    logic [ADDR_W-1:0] tmo_addr;
    logic              tmo_master;

    // Arbiter side
    modport slave (
        input  m0_stb, m0_we, m0_addr, m0_dout,
        input  m1_stb, m1_we, m1_addr, m1_dout,
        input  bus_din, bus_ack,
        output m0_din, m0_ack, m1_din, m1_ack,
        output bus_stb, bus_we, bus_addr, bus_dout,
        output tmo, tmo_addr, tmo_master
    );

    // Masters, slave mux and monitor side
    modport master (
        output m0_stb, m0_we, m0_addr, m0_dout,
        output m1_stb, m1_we, m1_addr, m1_dout,
        output bus_din, bus_ack,
        input  m0_din, m0_ack, m1_din, m1_ack,
        input  bus_stb, bus_we, bus_addr, bus_dout,
        input  tmo, tmo_addr, tmo_master
    );

endinterface

`default_nettype wire

// File: rtl/bus_tmo.sv
// ============================================================================
// Module   : bus_tmo
// Brief    : Bus watchdog counter; expired marks the last allowed wait cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_tmo #(
    parameter int TMO_CYCLES = 1024
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic run,
    input  wire logic clr,
    output logic      expired
);

    localparam int               CNT_W  = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TMO_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    // clr wins so the count never runs past c_LAST
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (clr) begin
            w_cnt_d = '0;
        end else if (run) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign expired = (r_cnt_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/bus_arb.sv
// ============================================================================
// Module   : bus_arb
// Brief    : Round-robin two-master arbiter with transfer watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arb
    import bus_arb_pkg::*;
#(
    parameter int TMO_CYCLES = 1024
) (
    input  wire logic clk,
    input  wire logic rst,
    bus_arb_if.slave  bif
);

    state_t            r_state_q, w_state_d;
    logic              r_ptr_q, w_ptr_d;
    logic [ADDR_W-1:0] r_tmo_addr_q, w_tmo_addr_d;
    logic              r_tmo_master_q, w_tmo_master_d;

    logic              w_granted;
    logic              w_sel;
    logic              w_stb;
    logic [ADDR_W-1:0] w_addr;
    logic              w_expired;
    logic              w_timeout;
    logic              w_done;
    logic              w_run;
    logic              w_clr;

    always_comb begin
        w_granted = (r_state_q == ST_GNT0) || (r_state_q == ST_GNT1);
        w_sel     = (r_state_q == ST_GNT1);
        w_stb     = w_sel ? bif.m1_stb  : bif.m0_stb;
        w_addr    = w_sel ? bif.m1_addr : bif.m0_addr;
        // A slave ack in the expiry cycle completes normally
        w_timeout = w_granted && !bif.bus_ack && w_expired;
        w_done    = w_granted && (bif.bus_ack || w_timeout);
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_ptr_d        = r_ptr_q;
        w_tmo_addr_d   = r_tmo_addr_q;
        w_tmo_master_d = r_tmo_master_q;
        case (r_state_q)
            ST_IDLE: begin
                if (bif.m0_stb && bif.m1_stb) begin
                    w_state_d = r_ptr_q ? ST_GNT1 : ST_GNT0;
                end else if (bif.m0_stb) begin
                    w_state_d = ST_GNT0;
                end else if (bif.m1_stb) begin
                    w_state_d = ST_GNT1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (w_done) begin
                    w_state_d = ST_IDLE;
                    w_ptr_d   = ~w_sel;
                    if (w_timeout) begin
                        w_tmo_addr_d   = w_addr;
                        w_tmo_master_d = w_sel;
                    end
                end else if (!w_stb) begin
                    // Abandoned request: release the bus, keep the pointer
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    assign w_run = w_granted && !bif.bus_ack;
    assign w_clr = (w_state_d == ST_IDLE);

    always_comb begin
        bif.bus_stb    = 1'b0;
        bif.bus_we     = 1'b0;
        bif.bus_addr   = '0;
        bif.bus_dout   = '0;
        bif.m0_ack     = 1'b0;
        bif.m0_din     = '0;
        bif.m1_ack     = 1'b0;
        bif.m1_din     = '0;
        bif.tmo        = w_timeout;
        bif.tmo_addr   = r_tmo_addr_q;
        bif.tmo_master = r_tmo_master_q;
        if (w_granted) begin
            bif.bus_stb  = w_stb && !w_timeout;
            bif.bus_we   = w_sel ? bif.m1_we   : bif.m0_we;
            bif.bus_addr = w_addr;
            bif.bus_dout = w_sel ? bif.m1_dout : bif.m0_dout;
            if (w_sel) begin
                bif.m1_ack = bif.bus_ack || w_timeout;
                bif.m1_din = w_timeout ? '0 : bif.bus_din;
            end else begin
                bif.m0_ack = bif.bus_ack || w_timeout;
                bif.m0_din = w_timeout ? '0 : bif.bus_din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_ptr_q        <= 1'b0;
            r_tmo_addr_q   <= '0;
            r_tmo_master_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_ptr_q        <= w_ptr_d;
            r_tmo_addr_q   <= w_tmo_addr_d;
            r_tmo_master_q <= w_tmo_master_d;
        end
    end

    bus_tmo #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .run     (w_run),
        .clr     (w_clr),
        .expired (w_expired)
    );

endmodule

`default_nettype wire

// File: tb/tb_bus_arb.sv
// ============================================================================
// Module   : tb_bus_arb
// Brief    : Self-checking bench for bus_arb (directed scenarios + random model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arb;

    localparam int TMO = 8;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    bus_arb_if bif ();

    bus_arb #(
        .TMO_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        bif.m0_stb = 1'b0; bif.m0_we = 1'b0; bif.m0_addr = '0; bif.m0_dout = '0;
        bif.m1_stb = 1'b0; bif.m1_we = 1'b0; bif.m1_addr = '0; bif.m1_dout = '0;
        bif.bus_ack = 1'b0; bif.bus_din = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({bif.bus_stb, bif.bus_we, bif.m0_ack, bif.m1_ack, bif.tmo, bif.tmo_master} !== 6'b0)
            begin errors++; $display("FAIL reset_ctl: got %b expected 000000",
                {bif.bus_stb, bif.bus_we, bif.m0_ack, bif.m1_ack, bif.tmo, bif.tmo_master}); end
        checks++;
        if (bif.bus_addr !== 30'h0 || bif.bus_dout !== 32'h0)
            begin errors++; $display("FAIL reset_bus: got addr=%h dout=%h expected 0", bif.bus_addr, bif.bus_dout); end
        checks++;
        if (bif.tmo_addr !== 30'h0)
            begin errors++; $display("FAIL reset_tmo_addr: got %h expected 0", bif.tmo_addr); end
        checks++;
        if (bif.m0_din !== 32'h0 || bif.m1_din !== 32'h0)
            begin errors++; $display("FAIL reset_din: got %h/%h expected 0", bif.m0_din, bif.m1_din); end
        cyc();
    endtask

    task automatic test_single_read();
        int hi;
        hi = 0;
        do_reset();
        bif.m0_stb = 1'b1; bif.m0_we = 1'b0; bif.m0_addr = 30'h0000_0010;
        @(negedge clk);
        checks++;
        if (bif.bus_stb !== 1'b0) begin errors++; $display("FAIL read_latency: got bus_stb=%b expected 0", bif.bus_stb); end
        cyc();
        for (int k = 1; k <= 3; k++) begin
            bif.bus_ack = (k == 3);
            bif.bus_din = (k == 3) ? 32'hDEAD_BEEF : 32'h0BAD_F00D;
            @(negedge clk);
            if (bif.bus_stb === 1'b1) hi++;
            checks++;
            if (bif.m1_ack !== 1'b0 || bif.m1_din !== 32'h0)
                begin errors++; $display("FAIL read_m1_quiet: got ack=%b din=%h expected 0", bif.m1_ack, bif.m1_din); end
            checks++;
            if (bif.m0_ack !== (k == 3))
                begin errors++; $display("FAIL read_m0_ack: cycle %0d got %b expected %b", k, bif.m0_ack, (k == 3)); end
            checks++;
            if (bif.bus_addr !== 30'h10 || bif.bus_we !== 1'b0)
                begin errors++; $display("FAIL read_bus: got addr=%h we=%b expected 10/0", bif.bus_addr, bif.bus_we); end
            if (k == 3) begin
                checks++;
                if (bif.m0_din !== 32'hDEAD_BEEF)
                    begin errors++; $display("FAIL read_data: got %h expected deadbeef", bif.m0_din); end
            end
            cyc();
        end
        drive_idle();
        @(negedge clk);
        checks++;
        if (bif.bus_stb !== 1'b0) begin errors++; $display("FAIL read_idle_after: got %b expected 0", bif.bus_stb); end
        checks++;
        if (hi != 3) begin errors++; $display("FAIL read_stb_cycles: got %0d expected 3", hi); end
        cyc();
    endtask

    task automatic test_contention();
        logic [29:0] a0, a1;
        a0 = 30'h111; a1 = 30'h222;
        do_reset();
        bif.m0_stb = 1'b1; bif.m0_addr = a0;
        bif.m1_stb = 1'b1; bif.m1_addr = a1;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            checks++;
            if (bif.bus_stb !== 1'b0) begin errors++; $display("FAIL cont_idle%0d: got %b expected 0", r, bif.bus_stb); end
            cyc();
            bif.bus_ack = 1'b1;
            @(negedge clk);
            checks++;
            if ({bif.bus_stb, bif.bus_addr, bif.m0_ack, bif.m1_ack} !== {1'b1, a0, 1'b1, 1'b0})
                begin errors++; $display("FAIL cont_first_m0_%0d: got stb=%b addr=%h ack=%b%b expected 1/%h/10",
                    r, bif.bus_stb, bif.bus_addr, bif.m0_ack, bif.m1_ack, a0); end
            cyc();
            bif.m0_stb = 1'b0; bif.bus_ack = 1'b0;
            if (r == 1) break;
            @(negedge clk);
            checks++;
            if (bif.bus_stb !== 1'b0) begin errors++; $display("FAIL cont_gap: got %b expected 0", bif.bus_stb); end
            cyc();
            bif.bus_ack = 1'b1;
            @(negedge clk);
            checks++;
            if ({bif.bus_stb, bif.bus_addr, bif.m0_ack, bif.m1_ack} !== {1'b1, a1, 1'b0, 1'b1})
                begin errors++; $display("FAIL cont_then_m1: got stb=%b addr=%h ack=%b%b expected 1/%h/01",
                    bif.bus_stb, bif.bus_addr, bif.m0_ack, bif.m1_ack, a1); end
            cyc();
            bif.m1_stb = 1'b0; bif.bus_ack = 1'b0;
            @(negedge clk);
            cyc();
            bif.m0_stb = 1'b1; bif.m1_stb = 1'b1;
        end
        drive_idle();
        cyc();
    endtask

    task automatic test_alternate();
        int q[$];
        do_reset();
        bif.m0_stb = 1'b1; bif.m0_addr = 30'h0AA;
        bif.m1_stb = 1'b1; bif.m1_addr = 30'h155;
        bif.bus_ack = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (bif.bus_stb === 1'b1) q.push_back((bif.bus_addr === 30'h0AA) ? 0 : 1);
            cyc();
        end
        checks++;
        if (q.size() != 8) begin errors++; $display("FAIL alt_count: got %0d grants expected 8", q.size()); end
        for (int i = 0; i < q.size() && i < 8; i++) begin
            checks++;
            if (q[i] != i % 2) begin errors++; $display("FAIL alt_order: grant %0d got m%0d expected m%0d", i, q[i], i % 2); end
        end
        drive_idle();
        cyc();
    endtask

    task automatic test_write();
        do_reset();
        bif.m1_stb = 1'b1; bif.m1_we = 1'b1; bif.m1_addr = 30'h0C00_0000; bif.m1_dout = 32'h1234_5678;
        @(negedge clk);
        cyc();
        for (int k = 1; k <= 2; k++) begin
            bif.bus_ack = (k == 2);
            @(negedge clk);
            checks++;
            if ({bif.bus_stb, bif.bus_we, bif.bus_addr, bif.bus_dout} !== {1'b1, 1'b1, 30'h0C00_0000, 32'h1234_5678})
                begin errors++; $display("FAIL write_pass: got stb=%b we=%b addr=%h dout=%h expected 1/1/0c000000/12345678",
                    bif.bus_stb, bif.bus_we, bif.bus_addr, bif.bus_dout); end
            checks++;
            if (bif.m1_ack !== (k == 2) || bif.m0_ack !== 1'b0)
                begin errors++; $display("FAIL write_ack: cycle %0d got m1=%b m0=%b expected %b/0", k, bif.m1_ack, bif.m0_ack, (k == 2)); end
            cyc();
        end
        drive_idle();
        cyc();
    endtask

    task automatic test_timeout();
        do_reset();
        bif.m0_stb = 1'b1; bif.m0_addr = 30'h155; bif.bus_din = 32'hFFFF_FFFF;
        @(negedge clk);
        cyc();
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            checks++;
            if (k < TMO) begin
                if ({bif.bus_stb, bif.m0_ack, bif.tmo} !== 3'b100)
                    begin errors++; $display("FAIL tmo_wait: cycle %0d got stb/ack/tmo=%b expected 100", k,
                        {bif.bus_stb, bif.m0_ack, bif.tmo}); end
            end else begin
                if ({bif.bus_stb, bif.m0_ack, bif.tmo, bif.m0_din} !== {3'b011, 32'h0})
                    begin errors++; $display("FAIL tmo_fire: got stb/ack/tmo=%b din=%h expected 011/0",
                        {bif.bus_stb, bif.m0_ack, bif.tmo}, bif.m0_din); end
            end
            cyc();
        end
        bif.m0_stb = 1'b0;
        @(negedge clk);
        checks++;
        if ({bif.bus_stb, bif.tmo, bif.tmo_addr, bif.tmo_master} !== {1'b0, 1'b0, 30'h155, 1'b0})
            begin errors++; $display("FAIL tmo_after: got stb=%b tmo=%b addr=%h master=%b expected 0/0/155/0",
                bif.bus_stb, bif.tmo, bif.tmo_addr, bif.tmo_master); end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bif.tmo_addr !== 30'h0) begin errors++; $display("FAIL tmo_addr_reset: got %h expected 0", bif.tmo_addr); end
        cyc();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bif.m1_stb = 1'b1; bif.m1_addr = 30'h222;
        @(negedge clk);
        cyc();
        @(negedge clk);
        checks++;
        if (bif.bus_stb !== 1'b1 || bif.bus_addr !== 30'h222)
            begin errors++; $display("FAIL rmid_grant: got stb=%b addr=%h expected 1/222", bif.bus_stb, bif.bus_addr); end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bif.m0_stb = 1'b1; bif.m0_addr = 30'h111;
        @(negedge clk);
        checks++;
        if ({bif.bus_stb, bif.m0_ack, bif.m1_ack} !== 3'b000)
            begin errors++; $display("FAIL rmid_abort: got stb/ack0/ack1=%b expected 000", {bif.bus_stb, bif.m0_ack, bif.m1_ack}); end
        cyc();
        bif.bus_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({bif.bus_stb, bif.bus_addr, bif.m0_ack, bif.m1_ack} !== {1'b1, 30'h111, 1'b1, 1'b0})
            begin errors++; $display("FAIL rmid_regrant: got stb=%b addr=%h ack=%b%b expected 1/111/10",
                bif.bus_stb, bif.bus_addr, bif.m0_ack, bif.m1_ack); end
        cyc();
        drive_idle();
        cyc();
    endtask

    task automatic test_drop();
        do_reset();
        bif.m1_stb = 1'b1; bif.m1_addr = 30'h222;
        @(negedge clk);
        cyc();
        cyc();
        bif.m1_stb = 1'b0;
        @(negedge clk);
        checks++;
        if (bif.bus_stb !== 1'b0 || bif.m1_ack !== 1'b0)
            begin errors++; $display("FAIL drop_now: got stb=%b ack=%b expected 0/0", bif.bus_stb, bif.m1_ack); end
        cyc();
        bif.m0_stb = 1'b1; bif.m0_addr = 30'h111; bif.m1_stb = 1'b1;
        @(negedge clk);
        checks++;
        if (bif.bus_stb !== 1'b0) begin errors++; $display("FAIL drop_idle: got %b expected 0", bif.bus_stb); end
        cyc();
        bif.bus_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (bif.bus_addr !== 30'h111 || bif.m0_ack !== 1'b1)
            begin errors++; $display("FAIL drop_pointer: got addr=%h ack0=%b expected 111/1", bif.bus_addr, bif.m0_ack); end
        cyc();
        drive_idle();
        cyc();
    endtask

    // Transaction-level model: who owns the bus, how long it has waited, whose turn is next
    task automatic test_random();
        logic        s[2], w[2];
        logic [29:0] a[2];
        logic [31:0] d[2];
        int          own, waited, pri, tmo_m;
        logic [29:0] tmo_a;
        logic        e_ack[2];
        logic [31:0] e_din[2];
        logic        e_stb, e_we, e_tmo, to;
        logic [29:0] e_addr;
        logic [31:0] e_dout;
        logic [161:0] exp_v, got_v;
        do_reset();
        own = -1; waited = 0; pri = 0; tmo_a = '0; tmo_m = 0;
        for (int i = 0; i < 2; i++) begin s[i] = 0; w[i] = 0; a[i] = '0; d[i] = '0; end
        for (int c = 0; c < 800; c++) begin
            bif.m0_stb = s[0]; bif.m0_we = w[0]; bif.m0_addr = a[0]; bif.m0_dout = d[0];
            bif.m1_stb = s[1]; bif.m1_we = w[1]; bif.m1_addr = a[1]; bif.m1_dout = d[1];
            bif.bus_ack = ($urandom_range(0, 2) == 0);
            bif.bus_din = $urandom;
            @(negedge clk);
            e_stb = 0; e_we = 0; e_addr = '0; e_dout = '0; e_tmo = 0; to = 0;
            e_ack[0] = 0; e_ack[1] = 0; e_din[0] = '0; e_din[1] = '0;
            if (own >= 0) begin
                to = !bif.bus_ack && (waited == TMO - 1);
                e_stb = s[own] && !to;
                e_we = w[own]; e_addr = a[own]; e_dout = d[own];
                e_ack[own] = bif.bus_ack || to;
                e_din[own] = to ? 32'h0 : bif.bus_din;
                e_tmo = to;
            end
            exp_v = {e_stb, e_we, e_addr, e_dout, e_ack[0], e_din[0], e_ack[1], e_din[1], e_tmo, tmo_a, tmo_m[0]};
            got_v = {bif.bus_stb, bif.bus_we, bif.bus_addr, bif.bus_dout, bif.m0_ack, bif.m0_din,
                     bif.m1_ack, bif.m1_din, bif.tmo, bif.tmo_addr, bif.tmo_master};
            checks++;
            if (got_v !== exp_v)
                begin errors++; $display("FAIL random_cycle%0d: got %h expected %h", c, got_v, exp_v); end
            if (own < 0) begin
                if (s[0] && s[1]) own = pri;
                else if (s[0]) own = 0;
                else if (s[1]) own = 1;
                waited = 0;
            end else if (bif.bus_ack || to) begin
                if (to) begin tmo_a = a[own]; tmo_m = own; end
                pri = 1 - own; own = -1; waited = 0;
            end else if (!s[own]) begin
                own = -1; waited = 0;
            end else begin
                waited++;
            end
            for (int i = 0; i < 2; i++) begin
                if ((s[i] && e_ack[i]) || (!s[i] && $urandom_range(0, 2) == 0)) begin
                    s[i] = s[i] ? ($urandom_range(0, 1) == 1) : 1'b1;
                    w[i] = $urandom_range(0, 1) == 1;
                    a[i] = 30'($urandom);
                    d[i] = $urandom;
                end
            end
            cyc();
        end
        drive_idle();
        cyc();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_single_read();
        test_contention();
        test_alternate();
        test_write();
        test_timeout();
        test_reset_mid();
        test_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
